// File: rtl/mdriver_regbank_pkg.sv
// Shared register-map constants and control register layout for mdriver_regbank.
package mdriver_regbank_pkg;

   // Byte addresses of the register map (bits [1:0] are not decoded)
   localparam int unsigned ADDR_CTRL    = 32'h00;
   localparam int unsigned ADDR_STATUS  = 32'h04;
   localparam int unsigned ADDR_TXDATA  = 32'h08;
   localparam int unsigned ADDR_RXDATA  = 32'h0C;
   localparam int unsigned ADDR_SCRATCH = 32'h10;

   // CTRL bit positions
   localparam int unsigned CTRL_ENABLE     = 0;
   localparam int unsigned CTRL_IRQ_EN_RX  = 1;
   localparam int unsigned CTRL_IRQ_EN_TXE = 2;
   localparam int unsigned CTRL_TX_FLUSH   = 3;
   localparam int unsigned CTRL_RX_FLUSH   = 4;

   // STATUS bit positions
   localparam int unsigned STAT_TX_FULL      = 0;
   localparam int unsigned STAT_TX_EMPTY     = 1;
   localparam int unsigned STAT_RX_EMPTY     = 2;
   localparam int unsigned STAT_RX_FULL      = 3;
   localparam int unsigned STAT_TX_DROP      = 5;
   localparam int unsigned STAT_TX_LEVEL_LSB = 8;
   localparam int unsigned STAT_RX_LEVEL_LSB = 16;
   localparam int unsigned LEVEL_W           = 8;

   // Stored CTRL bits; flush bits are strobes and are never stored
   typedef struct packed {
      logic irq_en_txe;
      logic irq_en_rx;
      logic enable;
   } ctrl_t;

endpackage

// File: rtl/mdriver_sync_fifo.sv
// Count-based synchronous FIFO; flush overrides push and pop in the same cycle.
module mdriver_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + LW'(1);
         else if (do_pop && !do_push) count <= count - LW'(1);
      end
   end

   // Storage array, no reset needed since occupancy governs validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mdriver_regbank.sv
// Register bank on the mdriver slave bus bridging TX/RX word streams via FIFOs.
// Optional feature: define MDRIVER_REGBANK_IRQ_EN to build the level interrupt
// and the CTRL interrupt-enable bits; otherwise irq is tied low.
module mdriver_regbank
   import mdriver_regbank_pkg::*;
#(
   parameter bit          OPT_READ_SIDEEFFECTS = 1'b1,
   parameter int unsigned C_AXI_DATA_WIDTH     = 32,
   parameter int unsigned C_AXI_ADDR_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH           = 8
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic [C_AXI_ADDR_WIDTH-1:0] si_address,
   input  logic [C_AXI_DATA_WIDTH-1:0] si_data,
   input  logic                        we,
   input  logic                        re,
   output logic [C_AXI_DATA_WIDTH-1:0] so_data,
   output logic [C_AXI_DATA_WIDTH-1:0] tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [C_AXI_DATA_WIDTH-1:0] rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic                        irq
);

   localparam int unsigned DW  = C_AXI_DATA_WIDTH;
   localparam int unsigned WAW = C_AXI_ADDR_WIDTH - 2;
   localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

   ctrl_t          ctrl_q;
   logic [DW-1:0]  scratch_q;
   logic [DW-1:0]  so_q;
   logic           tx_drop_q;
   logic [DW-1:0]  rdata_c;

   logic [WAW-1:0] word;
   logic [1:0]     unused_addr_lsb;
   logic           sel_ctrl, sel_status, sel_tx, sel_rx, sel_scratch;
   logic           rd;

   logic           tx_push, tx_pop, tx_flush, tx_full, tx_empty;
   logic           rx_push, rx_pop, rx_flush, rx_full, rx_empty;
   logic [LW-1:0]  tx_level, rx_level;
   logic [DW-1:0]  tx_head, rx_head;

   assign word            = si_address[C_AXI_ADDR_WIDTH-1:2];
   assign unused_addr_lsb = si_address[1:0];
   assign sel_ctrl        = (word == WAW'(ADDR_CTRL    >> 2));
   assign sel_status      = (word == WAW'(ADDR_STATUS  >> 2));
   assign sel_tx          = (word == WAW'(ADDR_TXDATA  >> 2));
   assign sel_rx          = (word == WAW'(ADDR_RXDATA  >> 2));
   assign sel_scratch     = (word == WAW'(ADDR_SCRATCH >> 2));
   // A write always wins over a same-cycle read
   assign rd              = re & ~we;

   assign tx_valid = ctrl_q.enable & ~tx_empty;
   assign rx_ready = ctrl_q.enable & ~rx_full;
   assign tx_data  = tx_head;
   assign so_data  = so_q;

   assign tx_flush = we & sel_ctrl & si_data[CTRL_TX_FLUSH];
   assign rx_flush = we & sel_ctrl & si_data[CTRL_RX_FLUSH];
   assign tx_push  = we & sel_tx & ~tx_full;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = (OPT_READ_SIDEEFFECTS ? rd : we) & sel_rx & ~rx_empty;

   mdriver_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk    (clk),
      .nreset (nreset),
      .push   (tx_push),
      .pop    (tx_pop),
      .flush  (tx_flush),
      .wdata  (si_data),
      .rdata  (tx_head),
      .level  (tx_level),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   mdriver_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk    (clk),
      .nreset (nreset),
      .push   (rx_push),
      .pop    (rx_pop),
      .flush  (rx_flush),
      .wdata  (rx_data),
      .rdata  (rx_head),
      .level  (rx_level),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   // Read-data decode from current register and FIFO state
   always_comb begin
      rdata_c = '0;
      if (sel_ctrl) begin
         rdata_c[CTRL_ENABLE]     = ctrl_q.enable;
         rdata_c[CTRL_IRQ_EN_RX]  = ctrl_q.irq_en_rx;
         rdata_c[CTRL_IRQ_EN_TXE] = ctrl_q.irq_en_txe;
      end else if (sel_status) begin
         rdata_c[STAT_TX_FULL]  = tx_full;
         rdata_c[STAT_TX_EMPTY] = tx_empty;
         rdata_c[STAT_RX_EMPTY] = rx_empty;
         rdata_c[STAT_RX_FULL]  = rx_full;
         rdata_c[STAT_TX_DROP]  = tx_drop_q;
         rdata_c[STAT_TX_LEVEL_LSB +: LEVEL_W] = LEVEL_W'(tx_level);
         rdata_c[STAT_RX_LEVEL_LSB +: LEVEL_W] = LEVEL_W'(rx_level);
      end else if (sel_rx) begin
         rdata_c = rx_empty ? '0 : rx_head;
      end else if (sel_scratch) begin
         rdata_c = scratch_q;
      end
   end

   // Bus-visible registers and registered read data
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ctrl_q    <= '0;
         scratch_q <= '0;
         tx_drop_q <= 1'b0;
         so_q      <= '0;
      end else begin
         if (rd) so_q <= rdata_c;
         if (we && sel_ctrl) begin
            ctrl_q.enable <= si_data[CTRL_ENABLE];
`ifdef MDRIVER_REGBANK_IRQ_EN
            ctrl_q.irq_en_rx  <= si_data[CTRL_IRQ_EN_RX];
            ctrl_q.irq_en_txe <= si_data[CTRL_IRQ_EN_TXE];
`endif
         end
         if (we && sel_scratch) scratch_q <= si_data;
         // Overflow is judged on pre-edge fullness, regardless of a same-cycle pop
         if (we && sel_tx && tx_full) tx_drop_q <= 1'b1;
         else if (we && sel_status && si_data[STAT_TX_DROP]) tx_drop_q <= 1'b0;
      end
   end

`ifdef MDRIVER_REGBANK_IRQ_EN
   logic irq_q;

   // Level interrupt sampled one cycle behind FIFO state
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) irq_q <= 1'b0;
      else         irq_q <= (ctrl_q.irq_en_rx & ~rx_empty) | (ctrl_q.irq_en_txe & tx_empty);
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mdriver_regbank.sv
// Self-checking bench for mdriver_regbank: directed register-map scenarios, then
// randomized bus and stream traffic against a queue-based reference model.
module tb_mdriver_regbank;

   localparam int unsigned D   = 8;
   localparam bit          OPT = 1'b1;
`ifdef MDRIVER_REGBANK_IRQ_EN
   localparam bit          IRQ = 1'b1;
`else
   localparam bit          IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [7:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] so_data;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] q_tx[$];
   logic [31:0] q_rx[$];
   bit          m_en, m_ien_rx, m_ien_txe, m_drop, m_irq;
   logic [31:0] m_scratch, m_so;

   mdriver_regbank #(
      .OPT_READ_SIDEEFFECTS (OPT),
      .C_AXI_DATA_WIDTH     (32),
      .C_AXI_ADDR_WIDTH     (8),
      .FIFO_DEPTH           (D)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .si_address (addr),
      .si_data    (wdata),
      .we         (we),
      .re         (re),
      .so_data    (so_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic model_reset();
      q_tx.delete();
      q_rx.delete();
      m_en = 0; m_ien_rx = 0; m_ien_txe = 0; m_drop = 0; m_irq = 0;
      m_scratch = '0; m_so = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int unsigned txn = q_tx.size();
      int unsigned rxn = q_rx.size();
      case (a)
         8'h00: return {29'b0, m_ien_txe, m_ien_rx, m_en};
         8'h04: return (32'(rxn) << 16) | (32'(txn) << 8) | (32'(m_drop) << 5)
                     | (32'(rxn == D) << 3) | (32'(rxn == 0) << 2)
                     | (32'(txn == 0) << 1) | 32'(txn == D);
         8'h0C: return (rxn == 0) ? 32'h0 : q_rx[0];
         8'h10: return m_scratch;
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs held during that edge
   task automatic model_edge();
      int unsigned txn = q_tx.size();
      int unsigned rxn = q_rx.size();
      bit          tx_v = m_en && (txn > 0);
      bit          rx_r = m_en && (rxn < D);
      bit          rd   = re && !we;
      logic [7:0]  a    = addr & 8'hFC;
      logic [31:0] rv   = m_read(a);
      bit          irq_n = (m_ien_rx && rxn > 0) || (m_ien_txe && txn == 0);
      bit          ftx  = we && a == 8'h00 && wdata[3];
      bit          frx  = we && a == 8'h00 && wdata[4];
      bit          rpop = (OPT ? rd : we) && a == 8'h0C && rxn > 0;
      if (rd) m_so = rv;
      if (ftx) q_tx.delete();
      else begin
         if (tx_v && tx_ready) void'(q_tx.pop_front());
         if (we && a == 8'h08) begin
            if (txn == D) m_drop = 1;
            else q_tx.push_back(wdata);
         end
      end
      if (frx) q_rx.delete();
      else begin
         if (rpop) void'(q_rx.pop_front());
         if (rx_valid && rx_r) q_rx.push_back(rx_data);
      end
      if (we && a == 8'h00) begin
         m_en = wdata[0];
         if (IRQ) begin
            m_ien_rx  = wdata[1];
            m_ien_txe = wdata[2];
         end
      end
      if (we && a == 8'h04 && wdata[5]) m_drop = 0;
      if (we && a == 8'h10) m_scratch = wdata;
      m_irq = irq_n;
   endtask

   task automatic step();
      bit mv;
      @(posedge clk);
      model_edge();
      #1;
      mv = m_en && (q_tx.size() > 0);
      check("so_data", so_data, m_so);
      check("tx_valid", 32'(tx_valid), 32'(mv));
      if (mv) check("tx_data", tx_data, q_tx[0]);
      check("rx_ready", 32'(rx_ready), 32'(m_en && q_rx.size() < D));
      check("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we = 1; re = 0; addr = a; wdata = d;
      step();
      we = 0;
   endtask

   task automatic rd(input logic [7:0] a);
      we = 0; re = 1; addr = a;
      step();
      re = 0;
   endtask

   task automatic async_reset();
      #2;
      nreset = 0;
      model_reset();
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_rx_ready", 32'(rx_ready), 32'h0);
      check("rst_so_data", so_data, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      nreset = 1;
   endtask

   logic [7:0] addr_tbl [12];

   initial begin
      int k;
      logic [31:0] d;
      addr_tbl = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h0A, 8'h0C, 8'h0C, 8'h0F,
                   8'h10, 8'h13, 8'h14, 8'hFC};
      model_reset();
      #12;
      check("rst_so_data", so_data, 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_rx_ready", 32'(rx_ready), 32'h0);
      @(negedge clk);
      nreset = 1;

      // Reset status
      rd(8'h04);
      check("rst_status", so_data, 32'h0000_0006);

      // Single TX word and drain
      wr(8'h00, 32'h1);
      wr(8'h08, 32'hA5);
      check("tx_one_valid", 32'(tx_valid), 32'h1);
      check("tx_one_data", tx_data, 32'hA5);
      rd(8'h04);
      check("tx_one_status", so_data, 32'h0000_0104);
      tx_ready = 1;
      step();
      tx_ready = 0;
      check("tx_drained", 32'(tx_valid), 32'h0);
      rd(8'h04);
      check("tx_empty_status", so_data, 32'h0000_0006);

      // Overflow and sticky drop
      for (int i = 0; i < 9; i++) wr(8'h08, 32'h100 + 32'(i));
      rd(8'h04);
      check("tx_full_drop", so_data, 32'h0000_0825);
      wr(8'h04, 32'h20);
      rd(8'h04);
      check("tx_drop_w1c", so_data, 32'h0000_0805);
      check("tx_full_head", tx_data, 32'h100);
      rd(8'h00);
      check("ctrl_read", so_data, 32'h1);
      wr(8'h00, 32'h9);
      rd(8'h04);
      check("tx_flush", so_data, 32'h0000_0006);
      rd(8'h00);
      check("flush_reads0", so_data, 32'h1);

      // RX stream then destructive reads
      rx_valid = 1; rx_data = 32'h11;
      step();
      rx_data = 32'h22;
      step();
      rx_valid = 0;
      rd(8'h0C);
      check("rx_first", so_data, 32'h11);
      rd(8'h0C);
      check("rx_second", so_data, 32'h22);
      rd(8'h0C);
      check("rx_empty_read", so_data, 32'h0);
      rd(8'h04);
      check("rx_empty_status", so_data, 32'h0000_0006);

      // Simultaneous write and read: write wins, so_data holds
      we = 1; re = 1; addr = 8'h10; wdata = 32'hDEAD;
      step();
      we = 0; re = 0;
      check("we_re_hold", so_data, 32'h0000_0006);
      rd(8'h10);
      check("scratch", so_data, 32'hDEAD);

      // Disable keeps contents
      wr(8'h08, 32'h77);
      wr(8'h00, 32'h0);
      check("disable_txv", 32'(tx_valid), 32'h0);
      check("disable_rxr", 32'(rx_ready), 32'h0);
      rd(8'h04);
      check("disable_keep", so_data, 32'h0000_0104);
      wr(8'h00, 32'h1);
      check("reenable_data", tx_data, 32'h77);

      // Interrupt on RX non-empty
      wr(8'h00, 32'h3);
      rd(8'h00);
      check("ctrl_irq_bits", so_data, IRQ ? 32'h3 : 32'h1);
      rx_valid = 1; rx_data = 32'hBEEF;
      step();
      rx_valid = 0;
      step();
      check("irq_set", 32'(irq), 32'(IRQ));
      rd(8'h0C);
      check("irq_pop_data", so_data, 32'hBEEF);
      step();
      check("irq_clear", 32'(irq), 32'h0);

      // Reset with data in flight
      rx_valid = 1; rx_data = 32'h55;
      step();
      rx_valid = 0;
      async_reset();
      rd(8'h04);
      check("post_rst_status", so_data, 32'h0000_0006);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         k = $urandom_range(0, 9);
         addr = addr_tbl[$urandom_range(0, 11)];
         d = $urandom();
         if ((addr & 8'hFC) == 8'h00) begin
            d = d & 32'h1F;
            if ($urandom_range(0, 7) != 0) d[4:3] = 2'b00;
            if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
         end
         wdata    = d;
         we       = (k >= 3 && k <= 5) || k == 9;
         re       = (k >= 6);
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = $urandom_range(0, 1) == 1;
         rx_data  = $urandom();
         step();
      end
      we = 0; re = 0; tx_ready = 0; rx_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
